dcache_ctrl: RTL and testbench

Blocking, single-outstanding-miss D-cache controller between the load/store queue (LSQ) and the D-cache array (`dcache_mem`). It accepts one load or store at a time and splits the address into tag and index. It sequences the array through lookup, dirty-victim writeback, fill and replay, and owns the processor-to-memory bus for data traffic. Its responses return to the LSQ.

---
 rtl/dcache_pkg.sv | 28 ++
 rtl/dcache_ctrl_perf.sv | 35 +++
 rtl/dcache_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and widths for the D-cache controller.
// Holds the controller state enum, the bus command encoding and the
// default address split (tag / index / 3-bit block offset).
package dcache_pkg;

  localparam int OFFSET_W    = 3;
  localparam int ADDR_W_DEF  = 64;
  localparam int INDEX_W_DEF = 3;
  localparam int BLOCK_W_DEF = 64;
  localparam int TAG_W_DEF   = ADDR_W_DEF - INDEX_W_DEF - OFFSET_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WB,
    S_FILL,
    S_WAIT,
    S_REPLAY,
    S_RESP
  } dcache_ctrl_state_t;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_cmd_t;

endpackage

// File: rtl/dcache_ctrl_perf.sv
// Saturating hit / miss / writeback event counters for the D-cache
// controller. Only instantiated when DCACHE_CTRL_PERF_EN is defined.
module dcache_ctrl_perf (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_hit,
  input  logic        i_miss,
  input  logic        i_wb,
  output logic [31:0] o_hit_count,
  output logic [31:0] o_miss_count,
  output logic [31:0] o_wb_count
);

  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;
  logic [31:0] r_wb_count;

  // Count each event, holding at all-ones instead of wrapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
      r_wb_count   <= '0;
    end else begin
      if (i_hit && (r_hit_count != '1))   r_hit_count  <= r_hit_count + 32'd1;
      if (i_miss && (r_miss_count != '1)) r_miss_count <= r_miss_count + 32'd1;
      if (i_wb && (r_wb_count != '1))     r_wb_count   <= r_wb_count + 32'd1;
    end
  end

  assign o_hit_count  = r_hit_count;
  assign o_miss_count = r_miss_count;
  assign o_wb_count   = r_wb_count;

endmodule

// File: rtl/dcache_ctrl.sv
// Blocking, single-outstanding-miss D-cache controller between the LSQ and
// the D-cache array. Sequences lookup, dirty-victim writeback, fill and
// replay, and owns the processor-to-memory bus.
// Optional: define DCACHE_CTRL_PERF_EN to add hit/miss/wb counters.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INDEX_W = INDEX_W_DEF,
  parameter int BLOCK_W = BLOCK_W_DEF,
  parameter int TAG_W   = ADDR_W - INDEX_W - OFFSET_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               lsq_req_valid,
  input  logic               lsq_req_is_store,
  input  logic [ADDR_W-1:0]  lsq_req_addr,
  input  logic [BLOCK_W-1:0] lsq_req_data,
  output logic               lsq_req_ready,
  output logic               lsq_resp_valid,
  output logic [BLOCK_W-1:0] lsq_resp_data,
  output logic [INDEX_W-1:0] dc_index,
  output logic [TAG_W-1:0]   dc_tag,
  output logic               dc_read_enable,
  output logic               dc_write_enable,
  output logic [BLOCK_W-1:0] dc_write_data,
  output logic [3:0]         dc_mem_response,
  output logic [3:0]         dc_mem_tag,
  output logic               dc_store_to_memory_enable,
  input  logic               dc_data_is_valid,
  input  logic               dc_data_is_miss,
  input  logic               dc_data_is_dirty,
  input  logic [BLOCK_W-1:0] dc_data_out,
  input  logic [BLOCK_W-1:0] dc_store_data,
  input  logic [TAG_W-1:0]   dc_victim_tag,
  output logic [1:0]         proc2mem_command,
  output logic [ADDR_W-1:0]  proc2mem_addr,
  output logic [BLOCK_W-1:0] proc2mem_data,
  input  logic [3:0]         mem2proc_response,
  input  logic [3:0]         mem2proc_tag
`ifdef DCACHE_CTRL_PERF_EN
  ,
  output logic [31:0]        hit_count,
  output logic [31:0]        miss_count,
  output logic [31:0]        wb_count
`endif
);

  dcache_ctrl_state_t r_state;
  dcache_ctrl_state_t w_next_state;
  bus_cmd_t           w_cmd;

  logic [ADDR_W-1:0]  r_addr;
  logic [BLOCK_W-1:0] r_data;
  logic               r_is_store;
  logic [3:0]         r_pend_tag;
  logic [BLOCK_W-1:0] r_victim;
  logic [TAG_W-1:0]   r_victim_tag;

  logic               w_accept;
  logic               w_victim_load;
  logic               w_pend_load;
  logic [INDEX_W-1:0] w_index;
  logic [TAG_W-1:0]   w_tag;
  logic               w_unused;

  // The array sees whole blocks, so the byte offset is never used.
  assign w_unused = ^{r_addr[OFFSET_W-1:0], dc_data_is_miss};

  assign w_index = r_addr[OFFSET_W +: INDEX_W];
  assign w_tag   = r_addr[OFFSET_W+INDEX_W +: TAG_W];

  // Array-facing fields are forced low during reset like every other output.
  assign dc_index         = reset ? '0 : w_index;
  assign dc_tag           = reset ? '0 : w_tag;
  assign dc_write_data    = reset ? '0 : r_data;
  assign dc_mem_tag       = mem2proc_tag;
  assign proc2mem_command = w_cmd;

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state decode plus all array, bus and LSQ strobes.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    w_next_state              = r_state;
    w_cmd                     = BUS_NONE;
    lsq_req_ready             = 1'b0;
    lsq_resp_valid            = 1'b0;
    lsq_resp_data             = '0;
    dc_read_enable            = 1'b0;
    dc_write_enable           = 1'b0;
    dc_mem_response           = '0;
    dc_store_to_memory_enable = 1'b0;
    proc2mem_addr             = '0;
    proc2mem_data             = '0;
    w_accept                  = 1'b0;
    w_victim_load             = 1'b0;
    w_pend_load               = 1'b0;
    if (!reset) begin
      unique case (r_state)
        S_IDLE: begin
          lsq_req_ready = 1'b1;
          if (lsq_req_valid) begin
            w_accept     = 1'b1;
            w_next_state = S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          dc_read_enable  = ~r_is_store;
          dc_write_enable = r_is_store;
          if (dc_data_is_valid) begin
            w_next_state = S_RESP;
          end else if (dc_data_is_dirty) begin
            w_victim_load = 1'b1;
            w_next_state  = S_WB;
          end else begin
            w_next_state = S_FILL;
          end
        end
        S_WB: begin
          w_cmd         = BUS_STORE;
          proc2mem_addr = {r_victim_tag, w_index, {OFFSET_W{1'b0}}};
          proc2mem_data = r_victim;
          if (mem2proc_response != 4'd0) begin
            dc_store_to_memory_enable = 1'b1;
            w_next_state              = S_FILL;
          end
        end
        S_FILL: begin
          w_cmd           = BUS_LOAD;
          proc2mem_addr   = {w_tag, w_index, {OFFSET_W{1'b0}}};
          dc_read_enable  = ~r_is_store;
          dc_write_enable = r_is_store;
          dc_mem_response = mem2proc_response;
          if (mem2proc_response != 4'd0) begin
            w_pend_load  = 1'b1;
            w_next_state = S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem2proc_tag == r_pend_tag) w_next_state = S_REPLAY;
        end
        S_REPLAY: begin
          dc_read_enable  = ~r_is_store;
          dc_write_enable = r_is_store;
          w_next_state    = S_RESP;
        end
        S_RESP: begin
          lsq_resp_valid = 1'b1;
          lsq_resp_data  = r_is_store ? '0 : dc_data_out;
          w_next_state   = S_IDLE;
        end
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // Latched request, victim and outstanding bus tag.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr       <= '0;
      r_data       <= '0;
      r_is_store   <= 1'b0;
      r_pend_tag   <= '0;
      r_victim     <= '0;
      r_victim_tag <= '0;
    end else begin
      if (w_accept) begin
        r_addr     <= lsq_req_addr;
        r_data     <= lsq_req_data;
        r_is_store <= lsq_req_is_store;
      end
      if (w_victim_load) begin
        r_victim     <= dc_store_data;
        r_victim_tag <= dc_victim_tag;
      end
      if (w_pend_load) r_pend_tag <= mem2proc_response;
    end
  end

`ifdef DCACHE_CTRL_PERF_EN
  logic w_hit;
  logic w_miss;

  assign w_hit  = !reset && (r_state == S_LOOKUP) && dc_data_is_valid;
  assign w_miss = !reset && (r_state == S_LOOKUP) && !dc_data_is_valid;

  dcache_ctrl_perf u_perf (
    .clock        (clock),
    .reset        (reset),
    .i_hit        (w_hit),
    .i_miss       (w_miss),
    .i_wb         (dc_store_to_memory_enable),
    .o_hit_count  (hit_count),
    .o_miss_count (miss_count),
    .o_wb_count   (wb_count)
  );
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl. The bench plays both the
// D-cache array (lookup results, read data) and the memory bus.
module tb_dcache_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        lsq_req_valid;
  logic        lsq_req_is_store;
  logic [63:0] lsq_req_addr;
  logic [63:0] lsq_req_data;
  logic        lsq_req_ready;
  logic        lsq_resp_valid;
  logic [63:0] lsq_resp_data;
  logic [2:0]  dc_index;
  logic [57:0] dc_tag;
  logic        dc_read_enable;
  logic        dc_write_enable;
  logic [63:0] dc_write_data;
  logic [3:0]  dc_mem_response;
  logic [3:0]  dc_mem_tag;
  logic        dc_store_to_memory_enable;
  logic        dc_data_is_valid;
  logic        dc_data_is_miss;
  logic        dc_data_is_dirty;
  logic [63:0] dc_data_out;
  logic [63:0] dc_store_data;
  logic [57:0] dc_victim_tag;
  logic [1:0]  proc2mem_command;
  logic [63:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_response;
  logic [3:0]  mem2proc_tag;
`ifdef DCACHE_CTRL_PERF_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
  logic [31:0] wb_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int load_cnt = 0;
  int load_snap;

  localparam logic [63:0] LINE40  = 64'hA5A5_0000_0000_0040;
  localparam logic [63:0] MEM80   = 64'h0BAD_CAFE_0000_0080;
  localparam logic [63:0] D1      = 64'h1111_2222_3333_4444;
  localparam logic [63:0] MEM440  = 64'h4400_4400_4400_0440;

  dcache_ctrl dut (
    .clock                     (clock),
    .reset                     (reset),
    .lsq_req_valid             (lsq_req_valid),
    .lsq_req_is_store          (lsq_req_is_store),
    .lsq_req_addr              (lsq_req_addr),
    .lsq_req_data              (lsq_req_data),
    .lsq_req_ready             (lsq_req_ready),
    .lsq_resp_valid            (lsq_resp_valid),
    .lsq_resp_data             (lsq_resp_data),
    .dc_index                  (dc_index),
    .dc_tag                    (dc_tag),
    .dc_read_enable            (dc_read_enable),
    .dc_write_enable           (dc_write_enable),
    .dc_write_data             (dc_write_data),
    .dc_mem_response           (dc_mem_response),
    .dc_mem_tag                (dc_mem_tag),
    .dc_store_to_memory_enable (dc_store_to_memory_enable),
    .dc_data_is_valid          (dc_data_is_valid),
    .dc_data_is_miss           (dc_data_is_miss),
    .dc_data_is_dirty          (dc_data_is_dirty),
    .dc_data_out               (dc_data_out),
    .dc_store_data             (dc_store_data),
    .dc_victim_tag             (dc_victim_tag),
    .proc2mem_command          (proc2mem_command),
    .proc2mem_addr             (proc2mem_addr),
    .proc2mem_data             (proc2mem_data),
    .mem2proc_response         (mem2proc_response),
    .mem2proc_tag              (mem2proc_tag)
`ifdef DCACHE_CTRL_PERF_EN
    ,
    .hit_count                 (hit_count),
    .miss_count                (miss_count),
    .wb_count                  (wb_count)
`endif
  );

  always #5 clock = ~clock;

  // Count bus cycles carrying BUS_LOAD, sampled mid-cycle.
  always @(negedge clock) begin
    if (proc2mem_command == 2'd1) load_cnt <= load_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    lsq_req_valid = 1'b0; lsq_req_is_store = 1'b0;
    lsq_req_addr = '0; lsq_req_data = '0;
    dc_data_is_valid = 1'b0; dc_data_is_miss = 1'b0; dc_data_is_dirty = 1'b0;
    dc_data_out = '0; dc_store_data = '0; dc_victim_tag = '0;
    mem2proc_response = '0; mem2proc_tag = '0;

    // Reset: all outputs low, including ready, during the reset cycle.
    tick();
    check("rst_ready", lsq_req_ready, 0);
    check("rst_cmd", proc2mem_command, 0);
    check("rst_resp_valid", lsq_resp_valid, 0);

    // Load hit at 0x40 (index 0, tag 1).
    reset = 1'b0;
    lsq_req_valid = 1'b1; lsq_req_is_store = 1'b0; lsq_req_addr = 64'h40;
    #1;
    check("idle_ready", lsq_req_ready, 1);
    tick();
    lsq_req_valid = 1'b0; dc_data_is_valid = 1'b1;
    #1;
    check("hit_read_en", dc_read_enable, 1);
    check("hit_write_en", dc_write_enable, 0);
    check("hit_index", dc_index, 0);
    check("hit_tag", dc_tag, 1);
    check("hit_lookup_ready", lsq_req_ready, 0);
    tick();
    dc_data_is_valid = 1'b0; dc_data_out = LINE40;
    #1;
    check("hit_resp_valid", lsq_resp_valid, 1);
    check("hit_resp_data", lsq_resp_data, LINE40);
    check("hit_bus_none", proc2mem_command, 0);
    tick();
    check("hit_done_valid", lsq_resp_valid, 0);
    check("hit_done_ready", lsq_req_ready, 1);

    // Clean load miss at 0x80 with a spurious tag during WAIT.
    load_snap = load_cnt;
    lsq_req_valid = 1'b1; lsq_req_addr = 64'h80;
    tick();
    lsq_req_valid = 1'b0; dc_data_is_miss = 1'b1;
    #1;
    check("miss_lookup_rd", dc_read_enable, 1);
    tick();
    dc_data_is_miss = 1'b0; mem2proc_response = 4'd3;
    #1;
    check("fill_cmd", proc2mem_command, 1);
    check("fill_addr", proc2mem_addr, 64'h80);
    check("fill_rd", dc_read_enable, 1);
    check("fill_mem_resp", dc_mem_response, 3);
    tick();
    mem2proc_response = 4'd0;
    #1;
    check("wait_cmd", proc2mem_command, 0);
    check("wait_mem_resp", dc_mem_response, 0);
    tick();
    mem2proc_tag = 4'd5;
    #1;
    check("wait_mem_tag_pass", dc_mem_tag, 5);
    tick();
    mem2proc_tag = 4'd0;
    #1;
    check("spurious_no_replay", dc_read_enable, 0);
    check("spurious_no_resp", lsq_resp_valid, 0);
    tick();
    mem2proc_tag = 4'd3;
    tick();
    mem2proc_tag = 4'd0;
    #1;
    check("replay_rd", dc_read_enable, 1);
    check("replay_no_resp", lsq_resp_valid, 0);
    tick();
    dc_data_out = MEM80;
    #1;
    check("miss_resp_valid", lsq_resp_valid, 1);
    check("miss_resp_data", lsq_resp_data, MEM80);
    check("miss_one_load", load_cnt - load_snap, 1);
    tick();

    // Store hit to 0x40 marks the line dirty.
    lsq_req_valid = 1'b1; lsq_req_is_store = 1'b1; lsq_req_addr = 64'h40; lsq_req_data = D1;
    tick();
    lsq_req_valid = 1'b0; lsq_req_data = '0; dc_data_is_valid = 1'b1;
    #1;
    check("st_write_en", dc_write_enable, 1);
    check("st_read_en", dc_read_enable, 0);
    check("st_write_data", dc_write_data, D1);
    tick();
    dc_data_is_valid = 1'b0; dc_data_out = 64'hDEAD;
    #1;
    check("st_resp_valid", lsq_resp_valid, 1);
    check("st_resp_data_zero", lsq_resp_data, 0);
    tick();

    // Load 0x440 (index 0, tag 0x11) evicts the dirty 0x40 line.
    lsq_req_valid = 1'b1; lsq_req_is_store = 1'b0; lsq_req_addr = 64'h440;
    tick();
    lsq_req_valid = 1'b0;
    dc_data_is_miss = 1'b1; dc_data_is_dirty = 1'b1; dc_store_data = D1; dc_victim_tag = 58'd1;
    #1;
    check("dirty_tag", dc_tag, 58'h11);
    load_snap = load_cnt;
    tick();
    dc_data_is_miss = 1'b0; dc_data_is_dirty = 1'b0; dc_store_data = '0; dc_victim_tag = '0;
    #1;
    check("wb_cmd", proc2mem_command, 2);
    check("wb_addr", proc2mem_addr, 64'h40);
    check("wb_data", proc2mem_data, D1);
    check("wb_no_ack", dc_store_to_memory_enable, 0);
    tick();
    mem2proc_response = 4'd5;
    #1;
    check("wb_retry_cmd", proc2mem_command, 2);
    check("wb_ack", dc_store_to_memory_enable, 1);
    check("wb_mem_resp_zero", dc_mem_response, 0);
    tick();
    // FILL with three refused cycles before acceptance.
    mem2proc_response = 4'd0;
    #1;
    check("dfill_cmd", proc2mem_command, 1);
    check("dfill_addr", proc2mem_addr, 64'h440);
    tick();
    tick();
    #1;
    check("dfill_hold_cmd", proc2mem_command, 1);
    tick();
    mem2proc_response = 4'd6;
    #1;
    check("dfill_mem_resp", dc_mem_response, 6);
    tick();
    mem2proc_response = 4'd0; mem2proc_tag = 4'd3;
    #1;
    check("retry_load_cycles", load_cnt - load_snap, 4);
    tick();
    mem2proc_tag = 4'd0;
    #1;
    check("stale_tag_ignored", dc_read_enable, 0);
    mem2proc_tag = 4'd6;
    tick();
    mem2proc_tag = 4'd0;
    #1;
    check("dreplay_rd", dc_read_enable, 1);
    tick();
    dc_data_out = MEM440;
    #1;
    check("dmiss_resp_valid", lsq_resp_valid, 1);
    check("dmiss_resp_data", lsq_resp_data, MEM440);
    tick();

    // Reset while in WAIT drops the transaction.
    lsq_req_valid = 1'b1; lsq_req_addr = 64'h18;
    tick();
    lsq_req_valid = 1'b0; dc_data_is_miss = 1'b1;
    #1;
    check("rw_index", dc_index, 3);
    tick();
    dc_data_is_miss = 1'b0; mem2proc_response = 4'd7;
    tick();
    mem2proc_response = 4'd0; reset = 1'b1;
    #1;
    check("rw_ready_in_reset", lsq_req_ready, 0);
    check("rw_index_in_reset", dc_index, 0);
    tick();
    reset = 1'b0;
    #1;
    check("rw_ready_after", lsq_req_ready, 1);
    mem2proc_tag = 4'd7;
    tick();
    mem2proc_tag = 4'd0;
    #1;
    check("rw_no_replay", dc_read_enable, 0);
    check("rw_no_resp", lsq_resp_valid, 0);
    tick();
    check("rw_no_resp2", lsq_resp_valid, 0);
    check("rw_ready_idle", lsq_req_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
